// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: word width, fetch FSM states, architectural reset/vector defaults.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_1000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h0000_2000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun,
    StMissWait,
    StTlbDrain
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sel.sv
// Next-PC priority mux: TLB vector > redirect (iret > branch > pending) > pc+4 > hold.
module pc_sel
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            take_vector,
  input  logic            pc_update,
  input  logic            advance,
  input  logic            iret,
  input  logic [XLEN-1:0] iret_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic [XLEN-1:0] new_target
);

  logic            new_redirect;
  logic [XLEN-1:0] redir_target;

  always_comb begin
    new_redirect = iret | branch_taken;
    new_target   = align_word(iret ? iret_pc : branch_target);
    // A fresh redirect supersedes one still waiting in the pending register.
    redir_target = new_redirect ? new_target : pend_target;
    redirect     = !take_vector && pc_update && (new_redirect || pend_valid);

    next_pc = pc;
    if (take_vector) begin
      next_pc = EXC_VECTOR;
    end else if (redirect) begin
      next_pc = redir_target;
    end else if (advance) begin
      next_pc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to the I-cache, and fills the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_fetch,
  output logic            ic_req,
  output logic [XLEN-1:0] ic_addr,
  input  logic            ic_ready,
  input  logic [XLEN-1:0] ic_rdata,
  input  logic            tlb_miss_instr,
  input  logic            last_stage_nop,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            iret,
  input  logic [XLEN-1:0] iret_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            block_pipe_instr_cache,
  output logic            tlb_miss_out,
  output logic [XLEN-1:0] exc_epc,
  output logic            exc_taken
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q;
  logic [XLEN-1:0] pend_target_q;

  logic            miss_now;
  logic            take_vector;
  logic            pc_update;
  logic            advance;
  logic            redirect;
  logic            capture;
  logic [XLEN-1:0] new_target;

  // Control decode: everything here is combinational from state and inputs.
  always_comb begin
    ic_req      = (state_q != StTlbDrain);
    ic_addr     = pc_q;
    miss_now    = ic_req && tlb_miss_instr;
    take_vector = (state_q == StTlbDrain) && last_stage_nop;
    pc_update   = en_fetch && !miss_now &&
                  ((state_q == StRun) || ((state_q == StMissWait) && ic_ready));
    advance     = pc_update && ic_ready;
    capture     = advance && !redirect;

    block_pipe_instr_cache = ic_req && !ic_ready && !tlb_miss_instr;
    tlb_miss_out           = miss_now || ((state_q == StTlbDrain) && !last_stage_nop);
    exc_taken              = take_vector;
  end

  pc_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_sel (
    .pc            (pc_q),
    .take_vector   (take_vector),
    .pc_update     (pc_update),
    .advance       (advance),
    .iret          (iret),
    .iret_pc       (iret_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_valid    (pend_valid_q),
    .pend_target   (pend_target_q),
    .next_pc       (pc_d),
    .redirect      (redirect),
    .new_target    (new_target)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (miss_now) begin
          state_d = StTlbDrain;
        end else if (redirect) begin
          state_d = StRun;
        end else if (!ic_ready) begin
          state_d = StMissWait;
        end
      end
      StMissWait: begin
        if (miss_now) begin
          state_d = StTlbDrain;
        end else if (ic_ready) begin
          state_d = StRun;
        end
      end
      StTlbDrain: begin
        if (last_stage_nop) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirects that cannot be applied yet wait here; the exception vector discards them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (take_vector || miss_now || redirect) begin
      pend_valid_q  <= 1'b0;
    end else if (iret || branch_taken) begin
      pend_valid_q  <= 1'b1;
      pend_target_q <= new_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (en_fetch) begin
      if_id_pc <= pc_q;
      if (capture) begin
        if_id_instr <= ic_rdata;
        if_id_valid <= 1'b1;
      end else begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_epc <= '0;
    end else if (miss_now) begin
      exc_epc <= pc_q;
    end
  end

endmodule
